lsu_stage: RTL
==============

# lsu_stage

Parametrised load/store unit replacing the single-access data-memory path of the memory stage. Adds a posted store buffer of configurable depth, store-to-load forwarding, per-byte lane generation, misalignment detection and a fence/drain mode. It sits between the execute/memory pipeline registers and the data-memory bus and stalls the pipeline only when a load misses the buffer, on partial overlap, on a full buffer, or on fence.

## Interface
- XLEN, 32, data/address width (32 or 64).
- SB_DEPTH, 4, store-buffer entries (power of two, ≥2).
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  instruction present in stage.
- i_memread / i_memwrite  in  1  load / store; never both set.
- i_f3  in  3  funct3 size/sign code.
- i_addr  in  XLEN  byte address (ALU result).
- i_wr_data  in  XLEN  store data, right-aligned.
- i_fence  in  1  drain request.
- o_rd  out  XLEN  sign/zero-extended load data.
- o_stall  out  1  hold pipeline (combinational).
- o_ex_ld / o_ex_st  out  1  load / store address exception.
- o_mem_req  out  1  bus request, held until ack.
- o_mem_we  out  1  1 = write.
- o_mem_addr  out  XLEN  word-aligned address.
- o_mem_wdata  out  XLEN  lane-aligned write data.
- o_mem_be  out  XLEN/8  byte enables.
- i_mem_ack  in  1  single-cycle transfer complete.
- i_mem_rdata  in  XLEN  read data, valid with ack.

## Operation
- f3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only). Other codes, or H/W/D not naturally aligned, raise o_ex_ld/o_ex_st combinationally; no buffer or bus effect, no stall.
- Store: enqueue {word addr, lane-shifted data, byte mask}; no stall unless full. Full with a pop in the same cycle: accepted, count unchanged.
- Load: compare word address against all valid entries, including one in flight. Youngest matching entry covers all needed bytes -> forward, o_rd valid same cycle, no stall. Any other match -> stall until all matching entries have drained, then issue to bus. No match -> issue to bus.
- FSM: IDLE, LD_REQ, ST_REQ. IDLE->LD_REQ on a load needing the bus (priority over drain). IDLE->ST_REQ if buffer non-empty and no load pending. LD_REQ/ST_REQ->IDLE on i_mem_ack. Store entry pops on its ack.
- Load data captured on ack into a register, extended per f3, then presented on o_rd.
- i_fence: stall until buffer empty and FSM IDLE.
- Stores drain in program order.

## Timing
- Reset: buffer empty, FSM IDLE, o_mem_req=0, o_mem_we=0, o_mem_addr/wdata/be=0, o_rd=0, o_stall=0, exceptions 0.
- Reset mid-transfer abandons the request; buffered stores are lost.
- Load miss, cycle 0 presented: o_stall=1; cycle 1 o_mem_req=1 (registered FSM). Ack in cycle k -> o_stall=0 and o_rd valid in cycle k+1. Minimum 2 stall cycles.
- Load arriving during ST_REQ stalls until that ack, then enters LD_REQ next cycle.
- Store drain: one bus transfer per ack; back-to-back drains leave one IDLE cycle between requests.
- Pipeline inputs are held stable while o_stall=1.

## Structure
- Package lsu_pkg: f3 encodings, state enum (IDLE, LD_REQ, ST_REQ), sb_entry_t {addr, data, be}, lane-mask and extend functions.
- Sub-module store_buffer: circular FIFO (head/tail/count) with parallel address-match/coverage lookup returning youngest-hit data and hit/partial flags.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100 before drain -> o_rd=0xDEADBEEF same cycle, no bus read, o_stall=0.
- SB 0x80 @0x101, then LB @0x101 -> forwarded o_rd=0xFFFFFF80; LBU -> 0x00000080.
- SB @0x102, then LW @0x100 -> stall until store acked, then bus read; o_rd = memory word including the new byte.
- LH @0x103 -> o_ex_ld=1, no request, o_stall=0; SW @0x102 -> o_ex_st=1, buffer count unchanged.
- SB_DEPTH stores with ack held low -> the next store stalls; first ack frees one slot and the store enqueues that cycle.
- i_fence with 3 buffered stores, ack every 2 cycles -> o_stall falls the cycle after the third ack, writes appear in order, reset mid-drain -> o_mem_req=0 immediately.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared encodings, store-buffer entry type and lane helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LD_REQ = 2'd1;
  localparam logic [1:0] S_ST_REQ = 2'd2;

  // Sized for the widest XLEN; narrower builds use the low bits only.
  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } sb_entry_t;

  function automatic logic [7:0] size_mask(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 8'h01;
      F3_H, F3_HU: return 8'h03;
      F3_W, F3_WU: return 8'h0F;
      default:     return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] word,
                                              input logic [2:0]  f3,
                                              input logic [2:0]  off);
    logic [63:0] s;
    s = word >> {off, 3'b000};
    case (f3)
      F3_B:    return {{56{s[7]}}, s[7:0]};
      F3_H:    return {{48{s[15]}}, s[15:0]};
      F3_W:    return {{32{s[31]}}, s[31:0]};
      F3_BU:   return {56'd0, s[7:0]};
      F3_HU:   return {48'd0, s[15:0]};
      F3_WU:   return {32'd0, s[31:0]};
      default: return s;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_stage_store_buffer.sv
// ============================================================================
// store_buffer : circular store FIFO with youngest-hit forwarding lookup
// Rev 1.0
// ============================================================================
`default_nettype none

module store_buffer
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [XLEN-1:0]   i_push_addr,
  input  logic [XLEN-1:0]   i_push_data,
  input  logic [XLEN/8-1:0] i_push_be,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [XLEN-1:0]   o_head_addr,
  output logic [XLEN-1:0]   o_head_data,
  output logic [XLEN/8-1:0] o_head_be,
  input  logic [XLEN-1:0]   i_lk_addr,
  input  logic [XLEN/8-1:0] i_lk_be,
  output logic              o_hit,
  output logic              o_partial,
  output logic [XLEN-1:0]   o_fwd_data
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = XLEN / 8;

  sb_entry_t       r_mem [SB_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [PW-1:0]   w_idx;
  logic            w_match;
  logic [BW-1:0]   w_ybe;
  logic [XLEN-1:0] w_ydata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_tail] <= '{addr: 64'(i_push_addr), data: 64'(i_push_data), be: 8'(i_push_be)};
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    w_idx   = '0;
    w_match = 1'b0;
    w_ybe   = '0;
    w_ydata = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (XLEN'(r_mem[w_idx].addr) == i_lk_addr)) begin
        w_match = 1'b1;
        w_ybe   = BW'(r_mem[w_idx].be);
        w_ydata = XLEN'(r_mem[w_idx].data);
      end
    end
  end

  assign o_hit       = w_match && ((w_ybe & i_lk_be) == i_lk_be);
  assign o_partial   = w_match && !o_hit;
  assign o_fwd_data  = w_ydata;
  assign o_full      = (r_count == CW'(SB_DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_addr = XLEN'(r_mem[r_head].addr);
  assign o_head_data = XLEN'(r_mem[r_head].data);
  assign o_head_be   = BW'(r_mem[r_head].be);

endmodule

`default_nettype wire

// File: rtl/lsu_stage.sv
// ============================================================================
// lsu_stage : load/store unit with posted store buffer and forwarding
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_stage
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_memread,
  input  logic              i_memwrite,
  input  logic [2:0]        i_f3,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wr_data,
  input  logic              i_fence,
  output logic [XLEN-1:0]   o_rd,
  output logic              o_stall,
  output logic              o_ex_ld,
  output logic              o_ex_st,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_be,
  input  logic              i_mem_ack,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam int BW   = XLEN / 8;
  localparam int OFFW = $clog2(BW);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_ld_done;
  logic [XLEN-1:0] r_ld_data;

  logic            w_legal;
  logic [OFFW-1:0] w_off;
  logic [XLEN-1:0] w_waddr;
  logic [BW-1:0]   w_be;
  logic [XLEN-1:0] w_st_data;
  logic            w_ld, w_st, w_push, w_pop, w_ld_bus;
  logic            w_full, w_empty, w_hit, w_partial;
  logic [XLEN-1:0] w_head_addr, w_head_data, w_fwd_data;
  logic [BW-1:0]   w_head_be;

  assign w_off     = i_addr[OFFW-1:0];
  assign w_waddr   = {i_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign w_be      = BW'(size_mask(i_f3) << w_off);
  assign w_st_data = i_wr_data << {w_off, 3'b000};

  always_comb begin
    case (i_f3)
      F3_B, F3_BU: w_legal = 1'b1;
      F3_H, F3_HU: w_legal = !i_addr[0];
      F3_W:        w_legal = (i_addr[1:0] == 2'b00);
      F3_WU:       w_legal = (XLEN == 64) && (i_addr[1:0] == 2'b00);
      F3_D:        w_legal = (XLEN == 64) && (i_addr[2:0] == 3'b000);
      default:     w_legal = 1'b0;
    endcase
  end

  assign o_ex_ld = i_valid && i_memread  && !w_legal;
  assign o_ex_st = i_valid && i_memwrite && !w_legal;
  assign w_ld    = i_valid && i_memread  && w_legal;
  assign w_st    = i_valid && i_memwrite && w_legal;
  assign w_pop   = (r_state == S_ST_REQ) && i_mem_ack;
  assign w_push  = w_st && (!w_full || w_pop);
  // r_ld_done keeps the completing load from re-requesting while it retires.
  assign w_ld_bus = w_ld && !w_hit && !w_partial && !r_ld_done;

  store_buffer #(.XLEN(XLEN), .SB_DEPTH(SB_DEPTH)) u_sb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_addr (w_waddr),
    .i_push_data (w_st_data),
    .i_push_be   (w_be),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_head_be   (w_head_be),
    .i_lk_addr   (w_waddr),
    .i_lk_be     (w_be),
    .o_hit       (w_hit),
    .o_partial   (w_partial),
    .o_fwd_data  (w_fwd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ld_bus)      w_state_nxt = S_LD_REQ;
        else if (!w_empty) w_state_nxt = S_ST_REQ;
      end
      S_LD_REQ, S_ST_REQ: if (i_mem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ld_done <= 1'b0;
      r_ld_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ld_done <= (r_state == S_LD_REQ) && i_mem_ack;
      if ((r_state == S_LD_REQ) && i_mem_ack) r_ld_data <= i_mem_rdata;
    end
  end

  always_comb begin
    o_rd = '0;
    if (w_ld && w_hit) o_rd = XLEN'(load_extend(64'(w_fwd_data), i_f3, 3'(w_off)));
    else if (r_ld_done) o_rd = XLEN'(load_extend(64'(r_ld_data), i_f3, 3'(w_off)));
  end

  assign o_stall = (w_ld && !w_hit && !r_ld_done)
                 || (w_st && w_full && !w_pop)
                 || (i_fence && !(w_empty && (r_state == S_IDLE)));

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    case (r_state)
      S_LD_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = w_waddr;
        o_mem_be   = w_be;
      end
      S_ST_REQ: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = w_head_addr;
        o_mem_wdata = w_head_data;
        o_mem_be    = w_head_be;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
